// File: rtl/tetris_step_scheduler.sv
// tetris_step_scheduler: arbitrates button edges and gravity ticks into valid/ready step transactions for the game core
module tetris_step_scheduler #(
  parameter int ACT_DIV    = 2500000,
  parameter int FALL_EVERY = 5
) (
  input  logic       CLK,
  input  logic       CLR_n,
  input  logic       run,
  input  logic       req_right,
  input  logic       req_left,
  input  logic       req_rotate,
  output logic       step_valid,
  input  logic       step_ready,
  output logic [1:0] step_op,
  output logic       step_fall,
  output logic [2:0] ack,
  output logic       overrun
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic [23:0] ACT_LAST  = 24'(ACT_DIV - 1);
  localparam logic [3:0]  GRAV_LAST = 4'(FALL_EVERY - 1);
  state_t      state_q, state_d;
  logic [23:0] act_cnt_q, act_cnt_d;
  logic [3:0]  grav_cnt_q, grav_cnt_d;
  logic [2:0]  pend_q, pend_d, prev_q, req, rise, take;
  logic [1:0]  step_op_q, step_op_d, op;
  logic        fall_pend_q, fall_pend_d, step_valid_q, step_valid_d;
  logic        step_fall_q, step_fall_d, overrun_q, overrun_d, slot, wrap;
  assign req  = {req_rotate, req_left, req_right};
  assign rise = req & ~prev_q;
  assign slot = run && act_cnt_q == ACT_LAST;
  assign wrap = slot && grav_cnt_q == GRAV_LAST;
  assign op   = pend_q[2] ? 2'd3 : pend_q[1:0] == 2'b11 ? 2'd0 : pend_q[1] ? 2'd1 : pend_q[0] ? 2'd2 : 2'd0;
  assign take = pend_q[2] ? 3'b100 : pend_q[1:0] == 2'b11 ? 3'b011 : pend_q[1] ? 3'b010 : pend_q[0] ? 3'b001 : 3'b000;
  assign ack  = state_q == ISSUE ? take : 3'b000;
  assign step_valid = step_valid_q;
  assign step_op    = step_op_q;
  assign step_fall  = step_fall_q;
  assign overrun    = overrun_q;
  always_comb begin
    state_d      = state_q;
    step_valid_d = step_valid_q;
    step_op_d    = step_op_q;
    step_fall_d  = step_fall_q;
    act_cnt_d    = run ? (slot ? 24'd0 : act_cnt_q + 24'd1) : act_cnt_q;
    grav_cnt_d   = slot ? (wrap ? 4'd0 : grav_cnt_q + 4'd1) : grav_cnt_q;
    // a fresh edge re-arms a bit even as ISSUE consumes it
    pend_d       = run ? ((pend_q & ~ack) | rise) : 3'b000;
    fall_pend_d  = wrap | (fall_pend_q & (state_q != ISSUE));
    overrun_d    = overrun_q | (slot & (state_q != IDLE));
    case (state_q)
      IDLE:  state_d = (slot && (|(pend_q | rise) || fall_pend_q || wrap)) ? ISSUE : IDLE;
      ISSUE: begin
        step_valid_d = 1'b1;
        step_op_d    = op;
        step_fall_d  = fall_pend_q;
        state_d      = WAIT;
      end
      WAIT: begin
        step_valid_d = step_ready ? 1'b0 : step_valid_q;
        state_d      = step_ready ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q      <= IDLE;
      act_cnt_q    <= '0;
      grav_cnt_q   <= '0;
      pend_q       <= '0;
      prev_q       <= '0;
      fall_pend_q  <= 1'b0;
      step_valid_q <= 1'b0;
      step_op_q    <= '0;
      step_fall_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_cnt_q    <= act_cnt_d;
      grav_cnt_q   <= grav_cnt_d;
      pend_q       <= pend_d;
      prev_q       <= req;
      fall_pend_q  <= fall_pend_d;
      step_valid_q <= step_valid_d;
      step_op_q    <= step_op_d;
      step_fall_q  <= step_fall_d;
      overrun_q    <= overrun_d;
    end
  end
endmodule

// File: tb/tb_tetris_step_scheduler.sv
// tb_tetris_step_scheduler: directed and random stimulus against a cycle model of the step scheduler rules
module tb_tetris_step_scheduler;
  localparam int AD = 4;
  localparam int FE = 2;
  logic clk = 1'b0, clr_n = 1'b0, run = 1'b0, rr = 1'b0, rl = 1'b0, rrot = 1'b0, ready = 1'b1;
  logic step_valid, step_fall, overrun;
  logic [1:0] step_op;
  logic [2:0] ack;
  int checks = 0, passes = 0, fails = 0, n_right = 0, right_before = 0;
  bit last_valid = 1'b0;
  logic [2:0] seen_ack = 3'b000;
  int m_cnt, m_grav;
  bit m_fallp, m_issuing, m_out, m_valid, m_fall, m_ovr;
  bit [2:0] m_pend, m_prev;
  bit [1:0] m_op;
  bit [2:0] rq;
  always #5 clk = ~clk;
  tetris_step_scheduler #(.ACT_DIV(AD), .FALL_EVERY(FE)) dut (
    .CLK(clk), .CLR_n(clr_n), .run(run), .req_right(rr), .req_left(rl), .req_rotate(rrot),
    .step_valid(step_valid), .step_ready(ready), .step_op(step_op), .step_fall(step_fall),
    .ack(ack), .overrun(overrun)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask
  // rotate wins; left+right together cancel each other; else left, then right
  function automatic void choose(input bit [2:0] p, output bit [1:0] op, output bit [2:0] used);
    if (p[2]) begin op = 2'd3; used = 3'b100; end
    else if (p[1] && p[0]) begin op = 2'd0; used = 3'b011; end
    else if (p[1]) begin op = 2'd1; used = 3'b010; end
    else if (p[0]) begin op = 2'd2; used = 3'b001; end
    else begin op = 2'd0; used = 3'b000; end
  endfunction
  task automatic model_reset();
    m_cnt = 0; m_grav = 0; m_fallp = 0; m_issuing = 0; m_out = 0;
    m_valid = 0; m_fall = 0; m_ovr = 0; m_pend = 0; m_prev = 0; m_op = 0;
    last_valid = 0;
  endtask
  task automatic model_step(input bit r, input bit [2:0] q, input bit rdy);
    bit [2:0] rise, used;
    bit [1:0] op;
    bit slot, wrap, n_issuing, n_out;
    rise = q & ~m_prev;
    slot = r && (m_cnt == AD - 1);
    wrap = slot && (m_grav == FE - 1);
    choose(m_pend, op, used);
    if (!m_issuing) used = 0;
    n_issuing = 0;
    n_out = m_out;
    if (m_issuing) begin m_valid = 1; m_op = op; m_fall = m_fallp; n_out = 1; end
    else if (m_out) begin if (rdy) begin m_valid = 0; n_out = 0; end end
    else if (slot && ((m_pend | rise) != 0 || m_fallp || wrap)) n_issuing = 1;
    m_ovr   = m_ovr | (slot && (m_issuing || m_out));
    m_fallp = wrap | (m_fallp & !m_issuing);
    m_pend  = r ? ((m_pend & ~used) | rise) : 3'b000;
    if (r) m_cnt = (m_cnt + 1) % AD;
    if (slot) m_grav = (m_grav + 1) % FE;
    m_issuing = n_issuing;
    m_out = n_out;
    m_prev = q;
  endtask
  task automatic check_all();
    bit [1:0] op;
    bit [2:0] used;
    choose(m_pend, op, used);
    chk("valid", 8'(step_valid), 8'(m_valid));
    chk("op", 8'(step_op), 8'(m_op));
    chk("fall", 8'(step_fall), 8'(m_fall));
    chk("ack", 8'(ack), m_issuing ? 8'(used) : 8'd0);
    chk("overrun", 8'(overrun), 8'(m_ovr));
  endtask
  task automatic cyc(input bit r, input bit [2:0] q, input bit rdy);
    run = r; {rrot, rl, rr} = q; ready = rdy;
    model_step(r, q, rdy);
    @(posedge clk);
    @(negedge clk);
    check_all();
    seen_ack |= ack;
    if (step_valid === 1'b1 && !last_valid && step_op === 2'd2) n_right++;
    last_valid = (step_valid === 1'b1);
  endtask
  task automatic wait_step(input string tag);
    for (int i = 0; i < 4 * AD; i++) begin
      cyc(1, 3'b000, 1);
      if (step_valid === 1'b1) break;
    end
    chk(tag, 8'(step_valid), 8'd1);
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    clr_n = 1'b1;
    // single left press: ack in ISSUE, valid one cycle later, then a fall-only step
    cyc(1, 3'b000, 1);
    cyc(1, 3'b010, 1);
    cyc(1, 3'b000, 1);
    cyc(1, 3'b000, 1);
    chk("t2_ack", 8'(ack), 8'b010);
    cyc(1, 3'b000, 1);
    chk("t2_valid", 8'(step_valid), 8'd1);
    chk("t2_op", 8'(step_op), 8'd1);
    chk("t2_fall", 8'(step_fall), 8'd0);
    repeat (4) cyc(1, 3'b000, 1);
    chk("t2_gvalid", 8'(step_valid), 8'd1);
    chk("t2_gop", 8'(step_op), 8'd0);
    chk("t2_gfall", 8'(step_fall), 8'd1);
    // simultaneous presses
    cyc(1, 3'b000, 1);
    seen_ack = 0;
    cyc(1, 3'b011, 1);
    wait_step("t3_lr_seen");
    chk("t3_lr_op", 8'(step_op), 8'd0);
    chk("t3_lr_ack", 8'(seen_ack), 8'b011);
    seen_ack = 0;
    cyc(1, 3'b110, 1);
    wait_step("t3_rl_seen");
    chk("t3_rl_op", 8'(step_op), 8'd3);
    chk("t3_rl_ack", 8'(seen_ack), 8'b100);
    wait_step("t3_left_seen");
    chk("t3_left_op", 8'(step_op), 8'd1);
    // held right button arms once
    repeat (3) cyc(1, 3'b000, 1);
    right_before = n_right;
    repeat (20) cyc(1, 3'b001, 1);
    repeat (8) cyc(1, 3'b000, 1);
    chk("t4_right_steps", 8'(n_right - right_before), 8'd1);
    // stalled handshake
    cyc(1, 3'b010, 0);
    for (int i = 0; i < 4 * AD && step_valid !== 1'b1; i++) cyc(1, 3'b000, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 3'b000, 0);
      chk("t5_hold_valid", 8'(step_valid), 8'd1);
    end
    chk("t5_overrun", 8'(overrun), 8'd1);
    wait_step("t5_next_seen");
    chk("t5_merged_fall", 8'(step_fall), 8'd1);
    // async reset while waiting on the datapath
    cyc(1, 3'b100, 0);
    for (int i = 0; i < 4 * AD && step_valid !== 1'b1; i++) cyc(1, 3'b000, 0);
    chk("t1_in_wait", 8'(step_valid), 8'd1);
    #2 clr_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    clr_n = 1'b1;
    cyc(1, 3'b010, 1);
    repeat (3) cyc(1, 3'b000, 1);
    chk("t1_no_early", 8'(step_valid), 8'd0);
    cyc(1, 3'b000, 1);
    chk("t1_step_after", 8'(step_valid), 8'd1);
    // run=0 discards requests and freezes timers
    repeat (2) cyc(1, 3'b000, 1);
    right_before = n_right;
    repeat (3) cyc(0, 3'b000, 1);
    cyc(0, 3'b001, 1);
    repeat (3) cyc(0, 3'b000, 1);
    repeat (12) cyc(1, 3'b000, 1);
    chk("t6_no_right", 8'(n_right - right_before), 8'd0);
    // random traffic
    rq = 3'b000;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(5) == 0) rq[b] = ~rq[b];
      cyc($urandom_range(7) != 0, rq, $urandom_range(2) != 0);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
